// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: per-sample rotation/vectoring mode, opaque tag,
// valid/ready handshake with a single global advance for back-pressure.
module cordic_pipe #(
    parameter int WIDTH      = 32,
    parameter int STAGES     = 16,
    parameter int ANGLE_FRAC = 10,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat
);

    localparam int XW = WIDTH + 2;
    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = ~MAX_V;

    typedef struct packed {
        logic [XW-1:0]    x;
        logic [XW-1:0]    y;
        logic [WIDTH-1:0] z;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } sample_t;

    // floor(atan(2^-i) * 2^30)
    function automatic logic [31:0] atan_q30(input int idx);
        case (idx)
            0:  return 32'd843314856;
            1:  return 32'd497837829;
            2:  return 32'd263043836;
            3:  return 32'd133525158;
            4:  return 32'd67021686;
            5:  return 32'd33543515;
            6:  return 32'd16775850;
            7:  return 32'd8388437;
            8:  return 32'd4194282;
            9:  return 32'd2097149;
            10: return 32'd1048575;
            11: return 32'd524287;
            12: return 32'd262143;
            13: return 32'd131071;
            14: return 32'd65535;
            15: return 32'd32767;
            16: return 32'd16383;
            17: return 32'd8191;
            18: return 32'd4095;
            19: return 32'd2047;
            20: return 32'd1023;
            21: return 32'd511;
            22: return 32'd255;
            23: return 32'd127;
            24: return 32'd63;
            25: return 32'd31;
            26: return 32'd15;
            27: return 32'd7;
            28: return 32'd3;
            29: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Overflow when the two guard bits and the WIDTH sign bit disagree.
    function automatic logic is_ovf(input logic [XW-1:0] v);
        return !((&v[XW-1:WIDTH-1]) || !(|v[XW-1:WIDTH-1]));
    endfunction

    function automatic logic [WIDTH-1:0] clip(input logic [XW-1:0] v);
        if (is_ovf(v))
            return v[XW-1] ? MIN_V : MAX_V;
        return v[WIDTH-1:0];
    endfunction

    logic              advance;
    logic [STAGES-1:0] vld;
    sample_t           pay [STAGES];
    sample_t           nxt [STAGES];
    sample_t           in_pay;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    always_comb begin
        in_pay      = '0;
        in_pay.x    = {{2{in_x[WIDTH-1]}}, in_x};
        in_pay.y    = {{2{in_y[WIDTH-1]}}, in_y};
        in_pay.z    = in_z;
        in_pay.mode = in_mode;
        in_pay.tag  = in_tag;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic [WIDTH-1:0] ATAN = WIDTH'(atan_q30(i) >> (30 - ANGLE_FRAC));

        sample_t       src;
        sample_t       res;
        logic          dir_pos;
        logic [XW-1:0] x_sh;
        logic [XW-1:0] y_sh;

        if (i == 0) begin : g_first
            assign src = in_pay;
        end else begin : g_rest
            assign src = pay[i-1];
        end

        assign x_sh    = $signed(src.x) >>> i;
        assign y_sh    = $signed(src.y) >>> i;
        assign dir_pos = src.mode ? src.y[XW-1] : !src.z[WIDTH-1];

        // NOTE: combinational logic uses blocking '=' with a full default first,
        // so every path assigns res and no latch is inferred.
        always_comb begin
            res = src;
            if (dir_pos) begin
                res.x = src.x - y_sh;
                res.y = src.y + x_sh;
                res.z = src.z - ATAN;
            end else begin
                res.x = src.x + y_sh;
                res.y = src.y - x_sh;
                res.z = src.z + ATAN;
            end
        end

        assign nxt[i] = res;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst)
            vld <= '0;
        else if (advance)
            vld <= STAGES'({vld, in_valid && in_ready});
    end

    // NOTE: the stage payload array is deliberately not reset; only the valid
    // bits qualify it, which keeps the wide datapath free of reset fan-out.
    always_ff @(posedge clk) begin
        if (advance)
            pay <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_mode  <= 1'b0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= vld[STAGES-1];
            out_x     <= clip(pay[STAGES-1].x);
            out_y     <= clip(pay[STAGES-1].y);
            out_z     <= pay[STAGES-1].z;
            out_mode  <= pay[STAGES-1].mode;
            out_tag   <= pay[STAGES-1].tag;
            out_sat   <= is_ovf(pay[STAGES-1].x) || is_ovf(pay[STAGES-1].y);
        end
    end

endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined CORDIC engine with a valid/ready handshake, a per-sample mode bit and a pass-through tag. It succeeds the fixed 16-stage rotation-only pipeline. Each sample can be a rotation (z driven to 0) or a vectoring (y driven to 0) operation. The block sits in the datapath between sample sources and downstream consumers, which may stall it.

## Interface
- WIDTH, 32: signed x/y/z width, two's complement
- STAGES, 16: micro-rotation stages, 1..32
- ANGLE_FRAC, 10: angle LSB = 2^-ANGLE_FRAC rad, 1..30
- TAG_W, 4: width of the opaque sideband tag
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts the sample this cycle
- in_x, in_y, in_z  in  WIDTH each  input vector and angle
- in_mode  in  1  0 = rotation, 1 = vectoring
- in_tag  in  TAG_W  carried unchanged to the output
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_x, out_y, out_z  out  WIDTH each  result (unscaled; gain K ≈ 1.6468)
- out_mode, out_tag  out  1 / TAG_W  copies of the input fields
- out_sat  out  1  out_x or out_y saturated

## Operation
- Pipeline: STAGES stage registers followed by one output register. Each register holds valid, x, y (WIDTH+2 bits, sign-extended guard), z, mode and tag.
- Stage i (i = 0..STAGES-1):
  - Direction d = +1 when rotation and z ≥ 0, or when vectoring and y < 0; otherwise d = -1.
  - x' = x - d·(y>>>i), y' = y + d·(x>>>i), z' = z - d·atan_i.
  - >>> is an arithmetic shift. All adds are in WIDTH+2 bits; z wraps modulo 2^WIDTH.
- atan_i = floor(atan(2^-i)·2^30) from a fixed 32-entry constant table, then >> (30-ANGLE_FRAC). For the default this gives 804, 474, 250, 127, 63, 31, 15, 7, 3, 1, then 0.
- Output register: x and y saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. out_sat = 1 if either saturated. z is truncated to WIDTH bits.
- Valid range:
  - Rotation: |z| ≤ π/2.
  - Vectoring: x > 0.
  - Out-of-range inputs produce defined but meaningless results; no error is raised.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance = 1, every register loads from its predecessor, and stage 0 loads in_valid & in_ready.
  - When advance = 0, all registers hold, bubbles included.
- Bubbles (valid = 0) flow like data; their payload is don't-care.

## Timing
- Reset: all valid bits 0. out_x, out_y, out_z, out_mode, out_tag and out_sat are 0, and in_ready is 1 on the cycle after reset.
- Reset mid-operation: all in-flight samples are discarded. out_valid is 0 on the cycle after the rst edge. in_ready is 0 while rst is high.
- Latency: a sample accepted on edge t gives out_valid = 1 after edge t+STAGES (STAGES+1 cycles, 17 by default), provided out_ready stays 1.
- Throughput: one sample per cycle while out_ready = 1.
- Stall: while out_valid & !out_ready, every output is stable and in_ready = 0.
- Ordering: no sample is dropped or duplicated across stalls, and output order equals input order.
- Simultaneous handshakes: if out_ready and in_valid rise in the same cycle, the held result is released and a new sample is accepted on the same edge.
- in_ready is combinational from out_ready and out_valid only, with no path from in_valid.

## Test plan
- Rotation, x=10000, y=0, z=0 → out_x = 16468 ±20, out_y = 0 ±20, out_z = 0 ±2. out_valid rises exactly 17 cycles after acceptance.
- Rotation, x=10000, y=0, z=804 (π/4) → out_x and out_y each 11644 ±20, out_sat = 0, out_tag equals in_tag.
- Vectoring, x=3000, y=4000, z=0 → out_x = 8234 ±20, out_y = 0 ±8, out_z = 949 ±4, out_mode = 1.
- Saturation: rotation, x = y = 2^31-1, z=804 → out_y = 0x7FFFFFFF, out_sat = 1.
- Back-pressure: stream 40 samples with tags 0..15 cycling, and toggle out_ready pseudo-randomly. Check:
  - Every result matches the reference model in the original order, with none lost or duplicated.
  - in_ready = 0 whenever out_valid & !out_ready.
  - Outputs are stable during stalls.
- Reset mid-stream: assert rst for 1 cycle with 10 samples in flight → out_valid = 0 and all outputs 0 the next cycle, none of the 10 appears, and a new sample returns after 17 cycles.
